// File: rtl/design_select_ctrl.sv
// design_select_ctrl: picks the design_sel code for the chip-level IO mux.
// The raw selection pins are synchronised and then debounced. A code is
// latched only after it has been stable for STABLE_CYCLES samples. The
// selected design is then held in reset for RST_HOLD cycles before release.
// IDLE_CODE is driven while no code is latched, so no design owns the pads
// during sampling.
module design_select_ctrl #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned RST_HOLD      = 8,
    parameter logic [4:0]  IDLE_CODE     = 5'h1F
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] sel_pins_i,
    input  logic       reselect_i,
    output logic [4:0] design_sel,
    output logic       design_rst_o,
    output logic       sel_valid_o,
    output logic [7:0] glitch_cnt_o
);

    localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int HCNT_W = $clog2(RST_HOLD + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        SAMPLE = 2'd0,
        HOLD   = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t            state;
    logic [4:0]        s1;
    logic [4:0]        s2;
    logic [4:0]        cand;
    logic [CNT_W-1:0]  cnt;
    logic [HCNT_W-1:0] hcnt;

    // Two-flop synchroniser for the asynchronous selection pins; only s2 is used.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments, so s2 takes
        // the old s1 at each edge instead of racing straight through.
        if (rst_i) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sel_pins_i;
            s2 <= s1;
        end
    end

    // Selection FSM: debounce, latch, hold the design in reset, then run.
    // Every output is registered here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= SAMPLE;
            cand         <= '0;
            cnt          <= '0;
            hcnt         <= '0;
            design_sel   <= IDLE_CODE;
            design_rst_o <= 1'b1;
            sel_valid_o  <= 1'b0;
            glitch_cnt_o <= '0;
        end else begin
            case (state)
                SAMPLE: begin
                    design_rst_o <= 1'b1;
                    sel_valid_o  <= 1'b0;
                    if (s2 == cand) begin
                        if (cnt == CNT_LAST) begin
                            // The code has been stable long enough. Hand it to
                            // the mux now, but keep the design in reset.
                            design_sel <= cand;
                            hcnt       <= '0;
                            state      <= HOLD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        // The sampled code moved: restart the stability run
                        // on the new value and record the glitch.
                        cand <= s2;
                        cnt  <= '0;
                        if (glitch_cnt_o != 8'hFF) begin
                            glitch_cnt_o <= glitch_cnt_o + 8'd1;
                        end
                    end
                end

                HOLD: begin
                    // Pins and reselect_i are ignored while the reset window runs.
                    if (hcnt == HCNT_LAST) begin
                        state        <= RUN;
                        design_rst_o <= 1'b0;
                        sel_valid_o  <= 1'b1;
                    end else begin
                        hcnt         <= hcnt + 1'b1;
                        design_rst_o <= 1'b1;
                        sel_valid_o  <= 1'b0;
                    end
                end

                RUN: begin
                    if (reselect_i) begin
                        // Back to sampling. The current synchronised pins
                        // become the first candidate, so this is not a glitch.
                        state        <= SAMPLE;
                        design_sel   <= IDLE_CODE;
                        design_rst_o <= 1'b1;
                        sel_valid_o  <= 1'b0;
                        cand         <= s2;
                        cnt          <= '0;
                    end else begin
                        design_rst_o <= 1'b0;
                        sel_valid_o  <= 1'b1;
                    end
                end

                default: begin
                    // Unused encoding: recover to sampling with no design selected.
                    state        <= SAMPLE;
                    design_sel   <= IDLE_CODE;
                    design_rst_o <= 1'b1;
                    sel_valid_o  <= 1'b0;
                    cnt          <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_design_select_ctrl.sv
// tb_design_select_ctrl: scoreboard bench for design_select_ctrl.
// The driver pushes timed expectations, and the negedge monitor pops and
// compares them.
module tb_design_select_ctrl;

    localparam int         STABLE = 4;
    localparam int         HOLD_N = 3;
    localparam logic [4:0] IDLE   = 5'h1F;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [4:0] sel_pins = 5'h00;
    logic       reselect = 1'b0;
    logic [4:0] design_sel;
    logic       design_rst;
    logic       sel_valid;
    logic [7:0] glitch_cnt;

    design_select_ctrl #(
        .STABLE_CYCLES(STABLE),
        .RST_HOLD     (HOLD_N),
        .IDLE_CODE    (IDLE)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .sel_pins_i  (sel_pins),
        .reselect_i  (reselect),
        .design_sel  (design_sel),
        .design_rst_o(design_rst),
        .sel_valid_o (sel_valid),
        .glitch_cnt_o(glitch_cnt)
    );

    always #5 clk = ~clk;

    // Free-running edge counter, used to time expectations.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        string      tag;
        logic [4:0] sel;
        logic       rst;
        logic       valid;
        logic [7:0] glitch;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input string tag, input int at, input logic [4:0] sel,
                        input logic rst, input logic valid, input logic [7:0] glitch);
        exp_t e;
        e.at     = at;
        e.tag    = tag;
        e.sel    = sel;
        e.rst    = rst;
        e.valid  = valid;
        e.glitch = glitch;
        sb.push_back(e);
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Monitor: compare every expectation due at this edge, half a cycle later.
    always @(negedge clk) begin : mon
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            if (e.at < cyc) begin
                check({e.tag, ".missed_edge"}, 32'(cyc), 32'(e.at));
            end else begin
                check({e.tag, ".sel"},    32'(design_sel), 32'(e.sel));
                check({e.tag, ".rst"},    32'(design_rst), 32'(e.rst));
                check({e.tag, ".valid"},  32'(sel_valid),  32'(e.valid));
                check({e.tag, ".glitch"}, 32'(glitch_cnt), 32'(e.glitch));
            end
        end
    end

    // Hold reset for two edges and check the reset state. Return at the negedge
    // where rst_i drops; edge k after release is then cyc c0+k.
    task automatic do_reset(input logic [4:0] pins, output int c0);
        rst_i    = 1'b1;
        sel_pins = pins;
        reselect = 1'b0;
        push("reset", cyc + 1, IDLE, 1'b1, 1'b0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        c0    = cyc;
    endtask

    // Wait until the scoreboard empties. Pending entries at timeout count as failures.
    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            $display("FAIL drain_timeout: pending=%0d expected=0", sb.size());
            n_checks += sb.size();
            n_fail   += sb.size();
            sb.delete();
        end
    endtask

    // Toggle pattern: alternates 1A/1B every 2 cycles up to cycle 20, then holds 1B.
    function automatic logic [4:0] toggle2(input int k);
        if (k > 20) return 5'h1B;
        return ((((k - 1) / 2) % 2) != 0) ? 5'h1B : 5'h1A;
    endfunction

    initial begin : drive
        int c0;
        int c1;
        @(negedge clk);

        // Pins at 1A from reset. The first mismatch comes at edge 3, the latch at edge 7 and the release at edge 10.
        do_reset(5'h1A, c0);
        for (int k = 1; k <= 6; k++)
            push($sformatf("s1_idle%0d", k), c0 + k, IDLE, 1'b1, 1'b0, (k >= 3) ? 8'd1 : 8'd0);
        push("s1_latch", c0 + 7, 5'h1A, 1'b1, 1'b0, 8'd1);
        push("s1_hold8", c0 + 8, 5'h1A, 1'b1, 1'b0, 8'd1);
        push("s1_hold9", c0 + 9, 5'h1A, 1'b1, 1'b0, 8'd1);
        push("s1_run",   c0 + 10, 5'h1A, 1'b0, 1'b1, 8'd1);
        drain(20);

        // Pins at 0 from reset. The latch comes at edge 4 and the release at edge 7, with no glitch.
        do_reset(5'h00, c0);
        for (int k = 1; k <= 3; k++)
            push($sformatf("s2_idle%0d", k), c0 + k, IDLE, 1'b1, 1'b0, 8'd0);
        push("s2_latch", c0 + 4, 5'h00, 1'b1, 1'b0, 8'd0);
        push("s2_hold6", c0 + 6, 5'h00, 1'b1, 1'b0, 8'd0);
        push("s2_run",   c0 + 7, 5'h00, 1'b0, 1'b1, 8'd0);
        drain(20);

        // Pins toggle every 2 cycles for 20 cycles. The sampled value changes at edges 3,5,...,21, giving 10 glitches.
        // After the last mismatch at edge 21, 1B latches at edge 25.
        do_reset(5'h1A, c0);
        for (int k = 1; k <= 24; k++)
            push($sformatf("s3_idle%0d", k), c0 + k, IDLE, 1'b1, 1'b0,
                 (k < 3) ? 8'd0 : 8'(min_i(10, (k - 3) / 2 + 1)));
        push("s3_latch", c0 + 25, 5'h1B, 1'b1, 1'b0, 8'd10);
        push("s3_hold",  c0 + 27, 5'h1B, 1'b1, 1'b0, 8'd10);
        push("s3_run",   c0 + 28, 5'h1B, 1'b0, 1'b1, 8'd10);
        for (int k = 1; k <= 28; k++) begin
            sel_pins = toggle2(k);
            @(negedge clk);
        end
        drain(5);

        // In RUN, a pin change is ignored. A reselect pulse at edge c1+5 drops back to sampling, and 03 latches 4 edges later.
        c1       = cyc;
        sel_pins = 5'h03;
        for (int k = 1; k <= 4; k++)
            push($sformatf("s4_run_ign%0d", k), c1 + k, 5'h1B, 1'b0, 1'b1, 8'd10);
        push("s4_resel", c1 + 5, IDLE, 1'b1, 1'b0, 8'd10);
        push("s4_samp8", c1 + 8, IDLE, 1'b1, 1'b0, 8'd10);
        push("s4_latch", c1 + 9, 5'h03, 1'b1, 1'b0, 8'd10);
        push("s4_hold",  c1 + 11, 5'h03, 1'b1, 1'b0, 8'd10);
        push("s4_run",   c1 + 12, 5'h03, 1'b0, 1'b1, 8'd10);
        repeat (4) @(negedge clk);
        reselect = 1'b1;
        @(negedge clk);
        reselect = 1'b0;
        drain(20);

        // Assert rst_i mid-HOLD, with hcnt=1 after edge 8. At edge 9 the block returns to reset values.
        do_reset(5'h1A, c0);
        push("s5_latch",   c0 + 7, 5'h1A, 1'b1, 1'b0, 8'd1);
        push("s5_hcnt1",   c0 + 8, 5'h1A, 1'b1, 1'b0, 8'd1);
        push("s5_midhold", c0 + 9, IDLE,  1'b1, 1'b0, 8'd0);
        repeat (8) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        drain(5);
        // After release, sampling restarts from scratch and follows the same timeline as before.
        do_reset(5'h1A, c0);
        push("s5_re_idle6", c0 + 6, IDLE,  1'b1, 1'b0, 8'd1);
        push("s5_re_latch", c0 + 7, 5'h1A, 1'b1, 1'b0, 8'd1);
        push("s5_re_run",   c0 + 10, 5'h1A, 1'b0, 1'b1, 8'd1);
        drain(20);

        // Pins toggle every cycle, so every edge from edge 3 on is a mismatch. The glitch count saturates at 255.
        do_reset(5'h1A, c0);
        push("s6_e2",   c0 + 2,   IDLE, 1'b1, 1'b0, 8'd0);
        push("s6_e3",   c0 + 3,   IDLE, 1'b1, 1'b0, 8'd1);
        push("s6_e100", c0 + 100, IDLE, 1'b1, 1'b0, 8'd98);
        push("s6_e256", c0 + 256, IDLE, 1'b1, 1'b0, 8'd254);
        push("s6_e257", c0 + 257, IDLE, 1'b1, 1'b0, 8'd255);
        push("s6_e258", c0 + 258, IDLE, 1'b1, 1'b0, 8'd255);
        push("s6_e300", c0 + 300, IDLE, 1'b1, 1'b0, 8'd255);
        for (int k = 1; k <= 300; k++) begin
            sel_pins = (k % 2 != 0) ? 5'h1A : 5'h1B;
            @(negedge clk);
        end
        drain(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute bound on the run.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
